// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode selectors and the TX/RX state encodings.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             rd_ok;
  logic             wr_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_buffered.sv
// UART with TX and RX FIFOs; RX entries carry their own parity and framing error flags.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV * STOP_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(DIV * STOP_BITS - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_fifo_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_pop;

  assign tx_pop  = (tx_state == TX_IDLE) && !tx_fifo_empty;
  assign tx_busy = (tx_state != TX_IDLE) || !tx_fifo_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(tx_wr && !tx_full), .din(tx_data), .full(tx_full),
    .rd(tx_pop), .dout(tx_head), .empty(tx_fifo_empty)
  );

  // tx is registered one state ahead so each symbol lines up with its state's DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_fifo_empty) begin
          tx_shift <= tx_head;
          tx_par   <= par_of(tx_head);
          tx       <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx       <= tx_shift[0];
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          if (tx_bit == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              tx       <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx       <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_PARITY: if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx       <= 1'b1;
          tx_state <= TX_STOP;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_STOP: if (tx_cnt == STOP_END) begin
          tx_cnt   <= '0;
          tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic [1:0]           rx_sync;
  logic                 rx_s;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr;
  logic                 rx_push;
  logic [DATA_BITS+1:0] rx_entry;
  logic                 rx_fifo_full;
  logic [DATA_BITS+1:0] rx_head;
  logic                 rx_pop_ok;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_sync <= '1;
    else       rx_sync <= {rx_sync[0], rx};
  end

  // The entry is pushed at the first stop bit's mid-point; the line is idle high from there on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_push  <= 1'b0;
      rx_entry <= '0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_END) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_perr  <= 1'b0;
          rx_state <= rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT)
            rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          else
            rx_bit <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_PARITY: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_perr  <= (rx_s != par_of(rx_shift));
          rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_push  <= 1'b1;
          rx_entry <= {!rx_s, rx_perr, rx_shift};
          rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_push), .din(rx_entry), .full(rx_fifo_full),
    .rd(rx_rd), .dout(rx_head), .empty(rx_empty)
  );

  assign {rx_frame_err, rx_parity_err, rx_data} = rx_head;
  assign rx_pop_ok = rx_rd && !rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     rx_overrun <= 1'b0;
    else if (rx_push && rx_fifo_full && !rx_pop_ok) rx_overrun <= 1'b1;
    else if (rx_pop_ok)                            rx_overrun <= 1'b0;
  end

endmodule
